// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// clock (meas_clk) in clk cycles, flags stability (locked) and absence (lost).
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   meas_clk   clock under measurement, asynchronous to clk
//   period     last measured meas_clk period, in clk cycles
//   high_time  high time belonging to the same period, in clk cycles
//   valid      one-cycle pulse, period/high_time updated this cycle
//   locked     high while consecutive periods differ by at most TOL
//   lost       high while meas_clk is declared absent
module clk_period_meter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000,
    parameter int unsigned TOL     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic s1, s2, s3;
    logic rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_shadow;
    logic [CNT_W-1:0] diff;
    logic             have_prev;
    logic             timeout_hit;
    logic             take_sample;
    logic             go_lost;
    logic             clr_lost;

    // Two-flop synchronizer plus one edge-detect register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= meas_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign fall        = ~s2 & s3;
    assign timeout_hit = (cnt == TIMEOUT_V);

    // Unsigned absolute difference between the new count and the previous period
    assign diff = (cnt >= period) ? (cnt - period) : (period - cnt);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes; a rise always wins over a timeout
    always_comb begin
        state_nxt   = state;
        take_sample = 1'b0;
        go_lost     = 1'b0;
        clr_lost    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                    go_lost   = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    take_sample = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                    go_lost   = 1'b1;
                end
            end
            LOST: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    clr_lost  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Free-running saturating cycle counter, restarted at 1 on every rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High-time capture; cleared on rise so a missing fall reports zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_shadow <= '0;
        end else if (rise) begin
            hi_shadow <= '0;
        end else if (fall) begin
            hi_shadow <= cnt;
        end
    end

    // Measurement outputs, lock and loss tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            lost      <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            valid <= take_sample;
            if (take_sample) begin
                period    <= cnt;
                high_time <= hi_shadow;
                locked    <= have_prev && (diff <= TOL_V);
                have_prev <= 1'b1;
            end else if (go_lost) begin
                period    <= '0;
                high_time <= '0;
                locked    <= 1'b0;
                have_prev <= 1'b0;
                lost      <= 1'b1;
            end
            if (clr_lost) begin
                lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: two instances (TOL=1 and TOL=0) share one
// meas_clk; a monitor records every valid pulse and the stimulus checks them.
module tb_clk_period_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 50;

    logic             clk;
    logic             rst_n;
    logic             meas_clk;
    logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
    logic             valid_a, locked_a, lost_a;
    logic             valid_b, locked_b, lost_b;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk),
        .period(period_a), .high_time(high_a), .valid(valid_a),
        .locked(locked_a), .lost(lost_a)
    );

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk),
        .period(period_b), .high_time(high_b), .valid(valid_b),
        .locked(locked_b), .lost(lost_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             lk;
        logic             lkb;
        logic             lost;
        logic             vb;
    } obs_t;

    typedef struct {
        int unsigned hi;
        int unsigned lo;
        int unsigned exp_p;
        int unsigned exp_h;
        logic        exp_lk;
        logic        exp_lkb;
    } vec_t;

    obs_t obs_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Record every valid pulse of instance A, sampled away from the active edge
    always @(negedge clk) begin
        if (valid_a) begin
            obs_t o;
            o.p    = period_a;
            o.h    = high_a;
            o.lk   = locked_a;
            o.lkb  = locked_b;
            o.lost = lost_a;
            o.vb   = valid_b;
            obs_q.push_back(o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_period(input int unsigned hi, input int unsigned lo);
        meas_clk = 1'b1;
        repeat (hi) tick();
        meas_clk = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic check_obs(input string tag, input int unsigned ep, input int unsigned eh,
                             input logic elk, input logic elkb);
        obs_t o;
        chk({tag, "_present"}, 32'(obs_q.size() > 0), 32'd1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk({tag, "_period"}, 32'(o.p), ep);
            chk({tag, "_high"}, 32'(o.h), eh);
            chk({tag, "_locked"}, 32'(o.lk), 32'(elk));
            chk({tag, "_locked_tol0"}, 32'(o.lkb), 32'(elkb));
            chk({tag, "_lost"}, 32'(o.lost), 32'd0);
            chk({tag, "_valid_b"}, 32'(o.vb), 32'd1);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{5, 5, 10, 5, 1'b0, 1'b0};
        vecs[1] = '{5, 5, 10, 5, 1'b1, 1'b1};
        vecs[2] = '{5, 5, 10, 5, 1'b1, 1'b1};
        vecs[3] = '{7, 7, 14, 7, 1'b0, 1'b0};
        vecs[4] = '{7, 7, 14, 7, 1'b1, 1'b1};
        vecs[5] = '{7, 7, 14, 7, 1'b1, 1'b1};
        vecs[6] = '{5, 5, 10, 5, 1'b0, 1'b0};
        vecs[7] = '{5, 6, 11, 5, 1'b1, 1'b0};
        vecs[8] = '{5, 5, 10, 5, 1'b1, 1'b0};
        vecs[9] = '{5, 6, 11, 5, 1'b1, 1'b0};

        meas_clk = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        chk("rst_period", 32'(period_a), 32'd0);
        chk("rst_high", 32'(high_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_lost", 32'(lost_a), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // First rise from IDLE produces no valid
        drive_period(vecs[0].hi, vecs[0].lo);
        chk("idle_first_rise_no_valid", 32'(obs_q.size()), 32'd0);
        for (int i = 1; i < 10; i++) begin
            drive_period(vecs[i].hi, vecs[i].lo);
            check_obs($sformatf("vec%0d", i - 1), vecs[i - 1].exp_p, vecs[i - 1].exp_h,
                      vecs[i - 1].exp_lk, vecs[i - 1].exp_lkb);
        end

        // Trailing rise closes the last row, then meas_clk stays low until timeout
        meas_clk = 1'b1;
        repeat (5) tick();
        check_obs("vec9", vecs[9].exp_p, vecs[9].exp_h, vecs[9].exp_lk, vecs[9].exp_lkb);
        meas_clk = 1'b0;
        repeat (15) tick();
        chk("hold_period", 32'(period_a), 32'd11);
        chk("hold_high", 32'(high_a), 32'd5);
        repeat (32) tick();
        chk("lost_not_yet", 32'(lost_a), 32'd0);
        tick();
        chk("lost_set", 32'(lost_a), 32'd1);
        chk("lost_period", 32'(period_a), 32'd0);
        chk("lost_high", 32'(high_a), 32'd0);
        chk("lost_locked", 32'(locked_a), 32'd0);
        chk("lost_b_set", 32'(lost_b), 32'd1);
        repeat (30) tick();
        chk("lost_held", 32'(lost_a), 32'd1);
        chk("lost_no_valid", 32'(obs_q.size()), 32'd0);

        // Recovery: rise clears lost; rise exactly at cnt==TIMEOUT is a valid sample
        meas_clk = 1'b1;
        repeat (2) tick();
        chk("recover_lost_still", 32'(lost_a), 32'd1);
        tick();
        chk("recover_lost_clear", 32'(lost_a), 32'd0);
        repeat (22) tick();
        meas_clk = 1'b0;
        repeat (25) tick();
        chk("recover_no_valid", 32'(obs_q.size()), 32'd0);
        meas_clk = 1'b1;
        repeat (5) tick();
        check_obs("edge_timeout", 50, 25, 1'b0, 1'b0);
        chk("edge_timeout_lost", 32'(lost_a), 32'd0);

        // Asynchronous reset mid-period
        #1 rst_n = 1'b0;
        #1;
        chk("arst_period", 32'(period_a), 32'd0);
        chk("arst_high", 32'(high_a), 32'd0);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_locked", 32'(locked_a), 32'd0);
        chk("arst_lost", 32'(lost_a), 32'd0);
        meas_clk = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        drive_period(5, 5);
        chk("arst_first_rise_no_valid", 32'(obs_q.size()), 32'd0);
        meas_clk = 1'b1;
        repeat (5) tick();
        check_obs("arst_first_valid", 10, 5, 1'b0, 1'b0);
        meas_clk = 1'b0;
        repeat (5) tick();
        chk("final_no_extra_valid", 32'(obs_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
